// File: rtl/audio_mixer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | audio_mixer_if                                                       |
// | Sample/control bundle between audio sources and the stereo mixer.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface audio_mixer_if #(
    parameter int NUM_CHANNELS = 4,
    parameter int IN_WIDTH     = 16,
    parameter int OUT_WIDTH    = 16,
    parameter int GAIN_WIDTH   = 8
);
    logic                               sample_strobe_i;
    logic [NUM_CHANNELS*IN_WIDTH-1:0]   chan_l_i;
    logic [NUM_CHANNELS*IN_WIDTH-1:0]   chan_r_i;
    logic [NUM_CHANNELS*GAIN_WIDTH-1:0] gain_i;
    logic [NUM_CHANNELS-1:0]            mute_i;
    logic                               clear_flags_i;
    logic [OUT_WIDTH-1:0]               audio_l_o;
    logic [OUT_WIDTH-1:0]               audio_r_o;
    logic                               valid_o;
    logic                               busy_o;
    logic                               clip_l_o;
    logic                               clip_r_o;
    logic                               overrun_o;

    modport master (
        output sample_strobe_i, chan_l_i, chan_r_i, gain_i, mute_i, clear_flags_i,
        input  audio_l_o, audio_r_o, valid_o, busy_o, clip_l_o, clip_r_o, overrun_o
    );

    modport slave (
        input  sample_strobe_i, chan_l_i, chan_r_i, gain_i, mute_i, clear_flags_i,
        output audio_l_o, audio_r_o, valid_o, busy_o, clip_l_o, clip_r_o, overrun_o
    );
endinterface
`default_nettype wire

// File: rtl/audio_mixer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | audio_mixer                                                          |
// | N-channel stereo mixer: per-channel gain/mute, one MAC per side,     |
// | saturated output, sticky clip/overrun flags.                         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module audio_mixer #(
    parameter int NUM_CHANNELS = 4,
    parameter int IN_WIDTH     = 16,
    parameter int OUT_WIDTH    = 16,
    parameter int GAIN_WIDTH   = 8,
    parameter int IN_SIGNED    = 0,
    parameter int OUT_SIGNED   = 0
) (
    input  logic         clk,
    input  logic         reset,
    audio_mixer_if.slave bus
);

    localparam int c_log_n = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 0;
    localparam int c_idx_w = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int c_acc_w = IN_WIDTH + GAIN_WIDTH + c_log_n + 1;
    localparam int c_shl   = OUT_WIDTH - IN_WIDTH;
    localparam int c_t_w   = c_acc_w + c_shl;

    localparam logic [c_idx_w-1:0]       c_last_idx = c_idx_w'(NUM_CHANNELS - 1);
    localparam logic [OUT_WIDTH-1:0]     c_out_zero =
        (OUT_SIGNED != 0) ? '0 : {1'b1, {(OUT_WIDTH-1){1'b0}}};
    localparam logic signed [c_t_w-1:0]  c_t_max =
        {{(c_t_w-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [c_t_w-1:0]  c_t_min =
        {{(c_t_w-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_SAT   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [NUM_CHANNELS*IN_WIDTH-1:0]   r_chan_l;
    logic [NUM_CHANNELS*IN_WIDTH-1:0]   r_chan_r;
    logic [NUM_CHANNELS*GAIN_WIDTH-1:0] r_gain;
    logic [NUM_CHANNELS-1:0]            r_mute;
    logic [c_idx_w-1:0]                 r_idx;
    logic signed [c_acc_w-1:0]          r_acc_l;
    logic signed [c_acc_w-1:0]          r_acc_r;
    logic [OUT_WIDTH-1:0]               r_audio_l;
    logic [OUT_WIDTH-1:0]               r_audio_r;
    logic                               r_clip_l;
    logic                               r_clip_r;
    logic                               r_overrun;

    logic signed [c_acc_w-1:0]          w_p_l;
    logic signed [c_acc_w-1:0]          w_p_r;
    logic [OUT_WIDTH:0]                 w_sat_l;
    logic [OUT_WIDTH:0]                 w_sat_r;

    // Signed sample times unsigned gain, arithmetic shift so unity gain is a no-op.
    function automatic logic signed [c_acc_w-1:0] scale(
        input logic [IN_WIDTH-1:0]   samp,
        input logic [GAIN_WIDTH-1:0] gain
    );
        logic [IN_WIDTH-1:0]       s2;
        logic signed [c_acc_w-1:0] se;
        logic signed [c_acc_w-1:0] ge;
        logic signed [c_acc_w-1:0] prod;
        s2 = samp;
        if (IN_SIGNED == 0) s2[IN_WIDTH-1] = ~s2[IN_WIDTH-1];
        se   = c_acc_w'($signed(s2));
        ge   = $signed({{(c_acc_w-GAIN_WIDTH){1'b0}}, gain});
        prod = se * ge;
        return prod >>> (GAIN_WIDTH - 1);
    endfunction

    // Returns {clipped, encoded output}.
    function automatic logic [OUT_WIDTH:0] sat_enc(input logic signed [c_acc_w-1:0] acc);
        logic signed [c_t_w-1:0] t;
        logic [OUT_WIDTH-1:0]    o;
        logic                    clip;
        t    = c_t_w'(acc) <<< c_shl;
        clip = 1'b1;
        if (t > c_t_max) begin
            o = c_t_max[OUT_WIDTH-1:0];
        end else if (t < c_t_min) begin
            o = c_t_min[OUT_WIDTH-1:0];
        end else begin
            o    = t[OUT_WIDTH-1:0];
            clip = 1'b0;
        end
        if (OUT_SIGNED == 0) o[OUT_WIDTH-1] = ~o[OUT_WIDTH-1];
        return {clip, o};
    endfunction

    always_comb begin
        w_p_l = '0;
        w_p_r = '0;
        if (!r_mute[r_idx]) begin
            w_p_l = scale(r_chan_l[r_idx*IN_WIDTH +: IN_WIDTH], r_gain[r_idx*GAIN_WIDTH +: GAIN_WIDTH]);
            w_p_r = scale(r_chan_r[r_idx*IN_WIDTH +: IN_WIDTH], r_gain[r_idx*GAIN_WIDTH +: GAIN_WIDTH]);
        end
        w_sat_l = sat_enc(r_acc_l);
        w_sat_r = sat_enc(r_acc_r);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (bus.sample_strobe_i) w_state_nxt = ST_ACCUM;
            ST_ACCUM: if (r_idx == c_last_idx) w_state_nxt = ST_SAT;
            ST_SAT:   w_state_nxt = ST_DONE;
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_chan_l  <= '0;
            r_chan_r  <= '0;
            r_gain    <= '0;
            r_mute    <= '0;
            r_idx     <= '0;
            r_acc_l   <= '0;
            r_acc_r   <= '0;
            r_audio_l <= c_out_zero;
            r_audio_r <= c_out_zero;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.sample_strobe_i) begin
                        r_chan_l <= bus.chan_l_i;
                        r_chan_r <= bus.chan_r_i;
                        r_gain   <= bus.gain_i;
                        r_mute   <= bus.mute_i;
                        r_idx    <= '0;
                        r_acc_l  <= '0;
                        r_acc_r  <= '0;
                    end
                end
                ST_ACCUM: begin
                    r_acc_l <= r_acc_l + w_p_l;
                    r_acc_r <= r_acc_r + w_p_r;
                    r_idx   <= r_idx + 1'b1;
                end
                ST_SAT: begin
                    r_audio_l <= w_sat_l[OUT_WIDTH-1:0];
                    r_audio_r <= w_sat_r[OUT_WIDTH-1:0];
                end
                default: ;
            endcase
        end
    end

    // Sticky flags: a new event in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_clip_l  <= 1'b0;
            r_clip_r  <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (r_state == ST_SAT && w_sat_l[OUT_WIDTH])      r_clip_l <= 1'b1;
            else if (bus.clear_flags_i)                       r_clip_l <= 1'b0;
            if (r_state == ST_SAT && w_sat_r[OUT_WIDTH])      r_clip_r <= 1'b1;
            else if (bus.clear_flags_i)                       r_clip_r <= 1'b0;
            if (bus.sample_strobe_i && r_state != ST_IDLE)    r_overrun <= 1'b1;
            else if (bus.clear_flags_i)                       r_overrun <= 1'b0;
        end
    end

    assign bus.audio_l_o = r_audio_l;
    assign bus.audio_r_o = r_audio_r;
    assign bus.valid_o   = (r_state == ST_DONE);
    assign bus.busy_o    = (r_state != ST_IDLE);
    assign bus.clip_l_o  = r_clip_l;
    assign bus.clip_r_o  = r_clip_r;
    assign bus.overrun_o = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_audio_mixer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_audio_mixer                                                       |
// | Directed scoreboard bench for audio_mixer (unsigned and signed).     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_audio_mixer;

    logic clk;
    logic reset;
    int   cyc;
    int   checks;
    int   errors;

    typedef struct {
        logic [15:0] l;
        logic [15:0] r;
        int          cyc;
    } exp_t;

    exp_t sb_u[$];
    exp_t sb_s[$];

    audio_mixer_if #(.NUM_CHANNELS(4), .IN_WIDTH(16), .OUT_WIDTH(16), .GAIN_WIDTH(8)) ifu ();
    audio_mixer_if #(.NUM_CHANNELS(4), .IN_WIDTH(16), .OUT_WIDTH(16), .GAIN_WIDTH(8)) ifs ();

    audio_mixer #(
        .NUM_CHANNELS(4), .IN_WIDTH(16), .OUT_WIDTH(16), .GAIN_WIDTH(8),
        .IN_SIGNED(0), .OUT_SIGNED(0)
    ) dut_u (
        .clk   (clk),
        .reset (reset),
        .bus   (ifu)
    );

    audio_mixer #(
        .NUM_CHANNELS(4), .IN_WIDTH(16), .OUT_WIDTH(16), .GAIN_WIDTH(8),
        .IN_SIGNED(1), .OUT_SIGNED(1)
    ) dut_s (
        .clk   (clk),
        .reset (reset),
        .bus   (ifs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitors: pop the scoreboard whenever a DUT presents valid_o.
    exp_t eu;
    always @(negedge clk) begin
        if (ifu.valid_o) begin
            if (sb_u.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL u_unexpected_valid: got valid at cycle %0d expected none", cyc);
            end else begin
                eu = sb_u.pop_front();
                check("u_audio_l", 32'(ifu.audio_l_o), 32'(eu.l));
                check("u_audio_r", 32'(ifu.audio_r_o), 32'(eu.r));
                check("u_valid_cycle", cyc, eu.cyc);
                check("u_busy_at_valid", 32'(ifu.busy_o), 32'd1);
            end
        end
    end

    exp_t es;
    always @(negedge clk) begin
        if (ifs.valid_o) begin
            if (sb_s.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL s_unexpected_valid: got valid at cycle %0d expected none", cyc);
            end else begin
                es = sb_s.pop_front();
                check("s_audio_l", 32'(ifs.audio_l_o), 32'(es.l));
                check("s_audio_r", 32'(ifs.audio_r_o), 32'(es.r));
                check("s_valid_cycle", cyc, es.cyc);
            end
        end
    end

    task automatic drive(input bit sgn, input logic [63:0] l, input logic [63:0] r,
                         input logic [31:0] g, input logic [3:0] m);
        if (sgn) begin
            ifs.chan_l_i = l; ifs.chan_r_i = r; ifs.gain_i = g; ifs.mute_i = m;
            ifs.sample_strobe_i = 1'b1;
        end else begin
            ifu.chan_l_i = l; ifu.chan_r_i = r; ifu.gain_i = g; ifu.mute_i = m;
            ifu.sample_strobe_i = 1'b1;
        end
    endtask

    task automatic drop_strobes();
        ifu.sample_strobe_i = 1'b0;
        ifs.sample_strobe_i = 1'b0;
    endtask

    // One complete mix; the expected result is queued before the strobe edge.
    task automatic mix(input bit sgn, input logic [63:0] l, input logic [63:0] r,
                       input logic [31:0] g, input logic [3:0] m,
                       input logic [15:0] el, input logic [15:0] er);
        exp_t e;
        @(negedge clk);
        drive(sgn, l, r, g, m);
        e = '{el, er, cyc + 6};
        if (sgn) sb_s.push_back(e);
        else     sb_u.push_back(e);
        @(negedge clk);
        drop_strobes();
        check(sgn ? "s_busy_start" : "u_busy_start",
              32'(sgn ? ifs.busy_o : ifu.busy_o), 32'd1);
        repeat (7) @(negedge clk);
    endtask

    task automatic clear_flags();
        @(negedge clk);
        ifu.clear_flags_i = 1'b1;
        ifs.clear_flags_i = 1'b1;
        @(negedge clk);
        ifu.clear_flags_i = 1'b0;
        ifs.clear_flags_i = 1'b0;
    endtask

    localparam logic [31:0] c_g_unity = 32'h8080_8080;
    localparam logic [63:0] c_all_b000 = 64'hB000_B000_B000_B000;

    initial begin
        cyc    = 0;
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        ifu.sample_strobe_i = 1'b0; ifu.clear_flags_i = 1'b0;
        ifu.chan_l_i = '0; ifu.chan_r_i = '0; ifu.gain_i = '0; ifu.mute_i = '0;
        ifs.sample_strobe_i = 1'b0; ifs.clear_flags_i = 1'b0;
        ifs.chan_l_i = '0; ifs.chan_r_i = '0; ifs.gain_i = '0; ifs.mute_i = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        check("rst_u_audio_l", 32'(ifu.audio_l_o), 32'h8000);
        check("rst_u_audio_r", 32'(ifu.audio_r_o), 32'h8000);
        check("rst_s_audio_l", 32'(ifs.audio_l_o), 32'h0000);
        check("rst_u_valid", 32'(ifu.valid_o), 32'd0);
        check("rst_u_busy", 32'(ifu.busy_o), 32'd0);
        check("rst_u_flags", {29'd0, ifu.clip_l_o, ifu.clip_r_o, ifu.overrun_o}, 32'd0);

        // Single channel at unity gain; muted channels carry full-scale junk.
        mix(0, 64'hFFFF_FFFF_FFFF_9000, 64'hFFFF_FFFF_FFFF_9000, c_g_unity, 4'b1110,
            16'h9000, 16'h9000);
        check("t1_clip_l", 32'(ifu.clip_l_o), 32'd0);

        // Mixed signs, half gain on ch2, floor rounding of -1.5 to -2 on the right.
        mix(0, {16'hFFFF, 16'h8100, 16'h7C00, 16'h9000},
               {16'hFFFF, 16'h7FFD, 16'h7FFF, 16'h8001},
               {8'h80, 8'h40, 8'h80, 8'h80}, 4'b1000, 16'h8C80, 16'h7FFE);

        // Positive saturation on both sides.
        mix(0, c_all_b000, c_all_b000, c_g_unity, 4'b0000, 16'hFFFF, 16'hFFFF);
        check("sat_clip_l", 32'(ifu.clip_l_o), 32'd1);
        check("sat_clip_r", 32'(ifu.clip_r_o), 32'd1);
        check("sat_overrun", 32'(ifu.overrun_o), 32'd0);
        clear_flags();
        check("clr_clip_l", 32'(ifu.clip_l_o), 32'd0);
        check("clr_clip_r", 32'(ifu.clip_r_o), 32'd0);

        // Gain scaling on ch0.
        mix(0, 64'hFFFF_FFFF_FFFF_A000, 64'hFFFF_FFFF_FFFF_7000, 32'h8080_8040, 4'b1110,
            16'h9000, 16'h7800);
        mix(0, 64'hFFFF_FFFF_FFFF_A000, 64'hFFFF_FFFF_FFFF_7000, 32'h8080_80FF, 4'b1110,
            16'hBFC0, 16'h6020);
        mix(0, 64'hFFFF_FFFF_FFFF_A000, 64'hFFFF_FFFF_FFFF_7000, 32'h8080_8000, 4'b1110,
            16'h8000, 16'h8000);
        check("gain_clip_l", 32'(ifu.clip_l_o), 32'd0);

        // Signed encoding passes values through unmodified at unity gain.
        mix(1, 64'h7FFF_7FFF_7FFF_1234, 64'h7FFF_7FFF_7FFF_F000, c_g_unity, 4'b1110,
            16'h1234, 16'hF000);
        check("s_clip_l_pre", 32'(ifs.clip_l_o), 32'd0);
        mix(1, 64'h8000_8000_8000_8000, 64'h8000_8000_8000_8000, c_g_unity, 4'b0000,
            16'h8000, 16'h8000);
        check("s_neg_clip_l", 32'(ifs.clip_l_o), 32'd1);

        // Strobe repeated at cycle 3: ignored, overrun raised, first inputs used.
        @(negedge clk);
        drive(0, 64'hFFFF_FFFF_FFFF_9000, 64'hFFFF_FFFF_FFFF_8800, c_g_unity, 4'b1110);
        sb_u.push_back('{16'h9000, 16'h8800, cyc + 6});
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 3) drive(0, c_all_b000, c_all_b000, 32'hFFFF_FFFF, 4'b0000);
            else        drop_strobes();
        end
        check("ovr_flag", 32'(ifu.overrun_o), 32'd1);
        clear_flags();
        check("ovr_clear", 32'(ifu.overrun_o), 32'd0);

        // Strobe in the DONE cycle is also an overrun and starts nothing.
        @(negedge clk);
        drive(0, 64'hFFFF_FFFF_FFFF_9000, 64'hFFFF_FFFF_FFFF_8800, c_g_unity, 4'b1110);
        sb_u.push_back('{16'h9000, 16'h8800, cyc + 6});
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 6) drive(0, c_all_b000, c_all_b000, c_g_unity, 4'b0000);
            else        drop_strobes();
        end
        check("done_ovr_flag", 32'(ifu.overrun_o), 32'd1);
        check("done_ovr_idle", 32'(ifu.busy_o), 32'd0);

        // Reset mid-mix discards the partial result.
        @(negedge clk);
        drive(0, c_all_b000, c_all_b000, c_g_unity, 4'b0000);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            drop_strobes();
            if (k == 3) reset = 1'b1;
        end
        check("mid_rst_audio_l", 32'(ifu.audio_l_o), 32'h8000);
        check("mid_rst_audio_r", 32'(ifu.audio_r_o), 32'h8000);
        check("mid_rst_busy", 32'(ifu.busy_o), 32'd0);
        check("mid_rst_overrun", 32'(ifu.overrun_o), 32'd0);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        mix(0, 64'hFFFF_FFFF_FFFF_9000, 64'hFFFF_FFFF_FFFF_9000, c_g_unity, 4'b1110,
            16'h9000, 16'h9000);

        repeat (5) @(negedge clk);
        check("sb_u_drained", sb_u.size(), 32'd0);
        check("sb_s_drained", sb_s.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/audio_mixer.md
Name: audio_mixer

Overview:
- Parametrised N-channel stereo audio mixer. It replaces the ad-hoc unsigned summing of SuperSprite, Mockingboard and speaker audio ahead of audio_out.
- Each channel has a per-channel gain and mute. Accumulation uses one time-multiplexed multiply-accumulate per side. Output is saturated, never wrapped.
- Sticky clip and overrun flags are exposed for LED/debug use.
- Sits between the card audio sources and audio_out core_l/core_r, in the clk_pixel domain.

Parameters:
- NUM_CHANNELS, 4, number of stereo input channels (1..16).
- IN_WIDTH, 16, bits per input sample.
- OUT_WIDTH, 16, bits per output sample; must be >= IN_WIDTH.
- GAIN_WIDTH, 8, gain bits per channel; unity gain = 2^(GAIN_WIDTH-1).
- IN_SIGNED, 0, 1 = inputs are two's complement, 0 = inputs are offset binary (unsigned).
- OUT_SIGNED, 0, output format, same encoding choice as IN_SIGNED.

Ports:
- clk, in, 1, mixer clock.
- reset, in, 1, asynchronous, active-high reset.
- sample_strobe_i, in, 1, one-cycle pulse; captures all inputs and starts a mix.
- chan_l_i, in, NUM_CHANNELS*IN_WIDTH, left samples; channel k occupies [k*IN_WIDTH +: IN_WIDTH].
- chan_r_i, in, NUM_CHANNELS*IN_WIDTH, right samples, same packing.
- gain_i, in, NUM_CHANNELS*GAIN_WIDTH, per-channel gain, same packing.
- mute_i, in, NUM_CHANNELS, 1 = channel contributes zero.
- clear_flags_i, in, 1, clears clip_l_o, clip_r_o and overrun_o.
- audio_l_o, out, OUT_WIDTH, mixed left output.
- audio_r_o, out, OUT_WIDTH, mixed right output.
- valid_o, out, 1, one-cycle pulse when audio_l_o/audio_r_o update.
- busy_o, out, 1, mix in progress.
- clip_l_o, out, 1, sticky: left output saturated.
- clip_r_o, out, 1, sticky: right output saturated.
- overrun_o, out, 1, sticky: strobe arrived while busy.

Behaviour:
- Reset values:
  - audio_l_o/audio_r_o = encoded zero: 0 if OUT_SIGNED, else 2^(OUT_WIDTH-1).
  - valid_o = 0, busy_o = 0, all flags = 0, FSM = IDLE, accumulators = 0.
- Reset is honoured mid-mix: the partial mix is discarded and valid_o is not pulsed.
- FSM states:
  - IDLE: on sample_strobe_i, register chan_l_i, chan_r_i, gain_i and mute_i into shadow registers, clear both accumulators, set channel index to 0 -> ACCUM.
  - ACCUM: one channel per cycle. For channel k:
    - s = shadow sample; if IN_SIGNED = 0, invert the MSB to get two's complement.
    - p = (s * gain_k) >>> (GAIN_WIDTH-1), arithmetic shift, signed × unsigned.
    - acc += mute_k ? 0 : p.
    - After channel NUM_CHANNELS-1 -> SAT.
  - SAT:
    - t = acc <<< (OUT_WIDTH-IN_WIDTH).
    - Clamp to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]; set clip_x if clamped.
    - Re-encode: invert the MSB if OUT_SIGNED = 0.
    - Register the outputs -> DONE.
  - DONE: valid_o = 1 for this cycle -> IDLE.
- Latency: strobe at cycle 0 -> valid_o at cycle NUM_CHANNELS+2. busy_o is high from cycle 1 through the valid_o cycle.
- Accumulator width = IN_WIDTH + GAIN_WIDTH + clog2(NUM_CHANNELS) + 1. It never wraps internally.
- sample_strobe_i while busy_o = 1:
  - Ignored: inputs are not recaptured and the current mix is unaffected.
  - overrun_o is set.
  - A strobe in the DONE cycle also counts as overrun.
- clear_flags_i in the same cycle as a new clip/overrun event: set wins, and the flag reads 1 next cycle.
- Outputs hold their value between valid_o pulses.
- gain_i and mute_i are sampled only at the strobe. Changes mid-mix take effect on the next sample.

Test Plan:
- Defaults, unsigned. Ch0 L = R = 0x9000 (+0x1000), gain 0x80, other channels muted, strobe -> valid_o at cycle 6; audio_l_o = audio_r_o = 0x9000.
- Four channels each +0x3000 (input 0xB000), gain 0x80 -> sum +0xC000 clamps to 0x7FFF; audio_l_o = 0xFFFF; clip_l_o = 1; clip_r_o also 1 when R matches L. Then clear_flags_i -> flags 0.
- Gain scaling. Ch0 = +0x2000, gain 0x40 -> +0x1000 (0x9000 out). Gain 0xFF -> +0x3FC0 (0xBFC0 out). Gain 0 -> 0x8000.
- Negative saturation, IN_SIGNED = OUT_SIGNED = 1. Four channels each 0x8000, gain 0x80 -> audio_l_o = 0x8000 (-32768); clip_l_o = 1.
- Strobe repeated at cycles 0 and 3 -> exactly one valid_o at cycle 6 carrying cycle-0 inputs; overrun_o = 1.
- Reset asserted at cycle 3 of a mix -> no valid_o; outputs 0x8000; busy_o = 0. Next strobe mixes correctly.
